board_line_streamer: RTL and testbench
======================================

# board_line_streamer

Streams the Connect-4 board to the four-in-a-row detector as a sequence of 2-bit pieces. It walks every line where a win is possible (rows, columns, and optionally diagonals), reading each cell from the board RAM. Each line is followed by a 2'b00 separator so the detector restarts between lines. It sits between the board RAM and the win-detection FSM and is triggered once per move.

## Interface
Parameters:
- ROWS, 6, board height; row 0 is the bottom row.
- COLS, 7, board width; cell address = row*COLS + col.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a scan; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- rd_addr  out  6  board RAM read address.
- rd_data  in  2  board RAM data; valid the cycle after rd_addr (synchronous read).
- out_piece  out  2  current piece: 00 empty/separator, 01 red, 10 yellow.
- out_valid  out  1  out_piece is valid.
- out_ready  in  1  consumer accepts the beat when out_valid and out_ready are both high.
- out_last  out  1  marks the final separator beat.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Reset values: busy 0, rd_addr 0, out_piece 00, out_valid 0, out_last 0, done 0. The line walker returns to the first coordinate.
- Scan order, with one 00 separator after each line:
  - Rows 0..5, each scanned col 0→6 (8 beats per row, 48 total).
  - Columns 0..6, each scanned row 0→5 (7 beats per column, 49 total).
  - Up-right diagonals, starting at (2,0), (1,0), (0,0), (0,1), (0,2), (0,3).
  - Up-left diagonals, starting at (0,3), (0,4), (0,5), (0,6), (1,6), (2,6).
  - Diagonal lengths are 4,5,6,6,5,4 per direction, giving 72 beats including separators.
- Total beats: 169 with diagonals, 97 without.
- Separator beats perform a dummy read. out_piece is forced to 00 on those beats.
- Output handshake:
  - Once out_valid rises, out_piece and out_last hold stable until the handshake completes.
  - out_valid never drops without a handshake, except on reset.
- Stall: while the output is stalled (out_valid & !out_ready), rd_addr holds and the walker does not advance. The synchronous RAM re-presents the same data, so no beat is lost or duplicated.
- The caller keeps the board RAM contents stable while busy is high.
- Reset mid-scan aborts the scan. All outputs return to reset values at the next edge, and the next start restarts from beat 0.
- start coincident with reset: reset wins.

## Timing
- start sampled at edge N: busy=1 and the first rd_addr are presented in cycle N+1. out_valid=1 with beat 0 in cycle N+2.
- With out_ready held high: one beat per cycle, no bubbles. Beat k appears in cycle N+2+k, so the last beat is in cycle N+170 (full) or N+98 (no diagonals).
- done pulses in the cycle after the out_last handshake. busy falls in the same cycle that done pulses.
- A new start is accepted in the done cycle or later.

## Configuration
- DIAGONALS_EN defined: diagonal lines are streamed; 169 beats, out_last on beat 168.
- DIAGONALS_EN undefined: only rows and columns are streamed; 97 beats, out_last on beat 96. The diagonal walker logic is absent.

## Structure
- connect4_pkg holds:
  - ROWS and COLS.
  - Piece codes EMPTY=2'b00, RED=2'b01, YELLOW=2'b10.
  - BEATS_FULL=169 and BEATS_NODIAG=97.
  - Line-kind enum {ROW, COL, DIAG_UR, DIAG_UL}.
- Sub-module line_walker holds the coordinate and line-kind state. It takes an advance input and outputs row, col, is_sep and is_last.
- The top level holds the read pipeline stage and the output register/handshake.

## Test plan
- Empty board, out_ready=1: 169 beats all 00, contiguous from N+2; out_last only on beat 168; done one cycle after.
- Red at addresses 0-3: beats 0-3 = 01, beat 7 = 00; beat 48 (column 0, row 0) = 01; beat 55 (column 1, row 0) = 01.
- Yellow at (0,6) = address 6: beat 6 = 10; beat 90 (column 6, row 0) = 10; first up-left diagonal (from (0,3)) unaffected.
- out_ready toggling 1/0 every cycle: the identical 169-beat sequence is produced; out_piece and out_last are stable across stalls; total time is about 2x.
- reset asserted at beat 50: out_valid=0 and busy=0 next cycle; a subsequent start yields beat 0 at start+2; a start pulsed while busy is ignored.
- DIAGONALS_EN undefined, empty board: 97 beats, out_last on beat 96, done one cycle after.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared board geometry, piece codes and scan bookkeeping types for the
// Connect-4 line streamer.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    localparam int BEATS_FULL   = 169;
    localparam int BEATS_NODIAG = 97;

    typedef enum logic [1:0] {ROW, COL, DIAG_UR, DIAG_UL} line_kind_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} scan_state_t;

endpackage

// File: rtl/board_line_streamer_if.sv
// Piece stream from the line streamer to the four-in-a-row detector.
interface board_line_streamer_if;
    logic [1:0] out_piece;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_piece, output out_valid, output out_last, input out_ready);
    modport slave  (input out_piece, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/board_line_streamer_line_walker.sv
// Walks every winnable line cell by cell, one separator step after each line.
// Diagonal lines are only walked when DIAGONALS_EN is defined.
module line_walker #(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          is_sep,
    output logic          is_last
);
    import connect4_pkg::*;

    line_kind_t    kind_q, kind_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          sep_q, sep_d;
    logic          line_end, final_line;

`ifdef DIAGONALS_EN
    localparam int NDIAG = ROWS + COLS - 7;
    logic [2:0] idx_q, idx_d, idx_n;

    // Diagonals of length >= 4 start on the left/right edge, then the bottom row.
    function automatic logic [RW-1:0] ur_row(input logic [2:0] i);
        return (int'(i) < ROWS - 3) ? RW'(ROWS - 4 - int'(i)) : '0;
    endfunction
    function automatic logic [CW-1:0] ur_col(input logic [2:0] i);
        return (int'(i) < ROWS - 3) ? '0 : CW'(int'(i) - (ROWS - 4));
    endfunction
    function automatic logic [RW-1:0] ul_row(input logic [2:0] i);
        return (int'(i) < COLS - 3) ? '0 : RW'(int'(i) - (COLS - 4));
    endfunction
    function automatic logic [CW-1:0] ul_col(input logic [2:0] i);
        return (int'(i) < COLS - 3) ? CW'(3 + int'(i)) : CW'(COLS - 1);
    endfunction

    assign idx_n      = idx_q + 3'd1;
    assign final_line = (kind_q == DIAG_UL) && (idx_q == 3'(NDIAG - 1));
`else
    assign final_line = (kind_q == COL) && (col_q == CW'(COLS - 1));
`endif

    always_comb begin
        line_end = 1'b0;
        case (kind_q)
            ROW:     line_end = (col_q == CW'(COLS - 1));
            COL:     line_end = (row_q == RW'(ROWS - 1));
`ifdef DIAGONALS_EN
            DIAG_UR: line_end = (row_q == RW'(ROWS - 1)) || (col_q == CW'(COLS - 1));
            DIAG_UL: line_end = (row_q == RW'(ROWS - 1)) || (col_q == '0);
`endif
            default: line_end = 1'b1;
        endcase
    end

    always_comb begin
        kind_d = kind_q;
        row_d  = row_q;
        col_d  = col_q;
        sep_d  = sep_q;
`ifdef DIAGONALS_EN
        idx_d  = idx_q;
`endif
        if (advance) begin
            if (!sep_q) begin
                if (line_end) begin
                    sep_d = 1'b1;
                end else begin
                    case (kind_q)
                        ROW: col_d = col_q + CW'(1);
                        COL: row_d = row_q + RW'(1);
`ifdef DIAGONALS_EN
                        DIAG_UR: begin
                            row_d = row_q + RW'(1);
                            col_d = col_q + CW'(1);
                        end
                        DIAG_UL: begin
                            row_d = row_q + RW'(1);
                            col_d = col_q - CW'(1);
                        end
`endif
                        default: ;
                    endcase
                end
            end else begin
                sep_d = 1'b0;
                if (final_line) begin
                    kind_d = ROW;
                    row_d  = '0;
                    col_d  = '0;
`ifdef DIAGONALS_EN
                    idx_d  = '0;
`endif
                end else begin
                    case (kind_q)
                        ROW: begin
                            col_d = '0;
                            if (row_q == RW'(ROWS - 1)) begin
                                kind_d = COL;
                                row_d  = '0;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end
                        COL: begin
                            row_d = '0;
                            col_d = col_q + CW'(1);
`ifdef DIAGONALS_EN
                            if (col_q == CW'(COLS - 1)) begin
                                kind_d = DIAG_UR;
                                idx_d  = '0;
                                row_d  = ur_row(3'd0);
                                col_d  = ur_col(3'd0);
                            end
`endif
                        end
`ifdef DIAGONALS_EN
                        DIAG_UR: begin
                            if (idx_q == 3'(NDIAG - 1)) begin
                                kind_d = DIAG_UL;
                                idx_d  = '0;
                                row_d  = ul_row(3'd0);
                                col_d  = ul_col(3'd0);
                            end else begin
                                idx_d = idx_n;
                                row_d = ur_row(idx_n);
                                col_d = ur_col(idx_n);
                            end
                        end
                        DIAG_UL: begin
                            idx_d = idx_n;
                            row_d = ul_row(idx_n);
                            col_d = ul_col(idx_n);
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kind_q <= ROW;
            row_q  <= '0;
            col_q  <= '0;
            sep_q  <= 1'b0;
        end else begin
            kind_q <= kind_d;
            row_q  <= row_d;
            col_q  <= col_d;
            sep_q  <= sep_d;
        end
    end

`ifdef DIAGONALS_EN
    always_ff @(posedge clock) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end
`endif

    assign row     = row_q;
    assign col     = col_q;
    assign is_sep  = sep_q;
    assign is_last = sep_q && final_line;
endmodule

// File: rtl/board_line_streamer.sv
// Streams every winnable board line (plus separators) from the board RAM to
// the win detector. Diagonal lines are included when DIAGONALS_EN is defined.
//
//   state   | meaning
//   S_IDLE  | waiting for start; walker parked at the first cell
//   S_RUN   | issuing reads, one per accepted beat
//   S_DRAIN | last beat issued, waiting for its handshake
module board_line_streamer #(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic [5:0]                   rd_addr,
    input  logic [1:0]                   rd_data,
    output logic                         done,
    board_line_streamer_if.master        stream
);
    import connect4_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    scan_state_t   state_q, state_d;
    logic          done_d;
    logic          load, hs, hs_last;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_sep, w_last;
    logic [5:0]    w_addr;
    logic          pb_valid, pb_sep, pb_last;
    logic [5:0]    pb_addr;

    line_walker #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_walker (
        .clock   (clock),
        .reset   (reset),
        .advance (load),
        .row     (w_row),
        .col     (w_col),
        .is_sep  (w_sep),
        .is_last (w_last)
    );

    assign w_addr  = 6'(int'(w_row) * COLS + int'(w_col));
    assign hs      = pb_valid && stream.out_ready;
    assign hs_last = hs && pb_last;
    assign load    = (state_q == S_RUN) && (!pb_valid || stream.out_ready);

    // While stalled the held beat's address is re-issued so the synchronous
    // RAM keeps presenting the same data on rd_data.
    assign rd_addr = load ? w_addr : pb_addr;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (load && w_last) state_d = S_DRAIN;
            S_DRAIN: if (hs_last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pb_valid <= 1'b0;
            pb_sep   <= 1'b0;
            pb_last  <= 1'b0;
            pb_addr  <= '0;
        end else if (load) begin
            pb_valid <= 1'b1;
            pb_sep   <= w_sep;
            pb_last  <= w_last;
            pb_addr  <= w_addr;
        end else if (hs) begin
            pb_valid <= 1'b0;
            pb_last  <= 1'b0;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign stream.out_valid = pb_valid;
    assign stream.out_last  = pb_valid && pb_last;
    assign stream.out_piece = (pb_valid && !pb_sep) ? rd_data : EMPTY;
endmodule

// File: tb/tb_board_line_streamer.sv
// Scoreboard bench for board_line_streamer: stimulus pushes the expected beat
// stream, a negedge monitor pops and compares every accepted beat.
module tb_board_line_streamer;
    import connect4_pkg::*;

`ifdef DIAGONALS_EN
    localparam int NB = BEATS_FULL;
`else
    localparam int NB = BEATS_NODIAG;
`endif

    typedef struct {
        logic [1:0] piece;
        bit         last;
        int         idx;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic [5:0] rd_addr;
    logic [1:0] rd_data = 2'b00;
    logic       done;
    logic [1:0] mem [0:63];

    board_line_streamer_if bus ();

    board_line_streamer dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .done    (done),
        .stream  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= mem[rd_addr];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   beat_cnt = 0;
    int   first_cyc = 0;
    bit   chk_timing = 0;
    int   last_hs_cyc = -100;
    bit   stalled_prev = 0;
    logic [1:0] held_piece;
    logic held_last;
    logic [1:0] got [0:NB-1];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (stalled_prev) begin
            check("stall_hold", {bus.out_valid, bus.out_piece, bus.out_last},
                  {1'b1, held_piece, held_last});
        end
        stalled_prev = bus.out_valid && !bus.out_ready && !reset;
        held_piece   = bus.out_piece;
        held_last    = bus.out_last;
        if (bus.out_valid && bus.out_ready && !reset) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", beat_cnt, -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (beat_cnt < NB) got[beat_cnt] = bus.out_piece;
                total++;
                if (bus.out_piece !== e.piece || bus.out_last !== e.last) begin
                    bad++;
                    $display("FAIL beat %0d: piece=%b last=%b expected piece=%b last=%b",
                             e.idx, bus.out_piece, bus.out_last, e.piece, e.last);
                end
                if (chk_timing) check("beat_cycle", cyc, first_cyc + beat_cnt);
            end
            beat_cnt++;
            if (bus.out_last) last_hs_cyc = cyc;
        end
        if (done && !reset) begin
            check("done_after_last", cyc, last_hs_cyc + 1);
            check("busy_in_done", int'(busy), 0);
        end
    end

    task automatic push_cell(input int a, input bit sep);
        exp_t e;
        e.piece = sep ? EMPTY : mem[a];
        e.last  = 1'b0;
        e.idx   = sb.size();
        sb.push_back(e);
    endtask

    task automatic push_scan();
        int r, c;
        int ur_r[6], ur_c[6], ul_r[6], ul_c[6];
        ur_r = '{2, 1, 0, 0, 0, 0};
        ur_c = '{0, 0, 0, 1, 2, 3};
        ul_r = '{0, 0, 0, 0, 1, 2};
        ul_c = '{3, 4, 5, 6, 6, 6};
        sb.delete();
        for (int rr = 0; rr < 6; rr++) begin
            for (int cc = 0; cc < 7; cc++) push_cell(rr * 7 + cc, 1'b0);
            push_cell(0, 1'b1);
        end
        for (int cc = 0; cc < 7; cc++) begin
            for (int rr = 0; rr < 6; rr++) push_cell(rr * 7 + cc, 1'b0);
            push_cell(0, 1'b1);
        end
`ifdef DIAGONALS_EN
        for (int d = 0; d < 6; d++) begin
            r = ur_r[d]; c = ur_c[d];
            while (r < 6 && c < 7) begin push_cell(r * 7 + c, 1'b0); r++; c++; end
            push_cell(0, 1'b1);
        end
        for (int d = 0; d < 6; d++) begin
            r = ul_r[d]; c = ul_c[d];
            while (r < 6 && c >= 0) begin push_cell(r * 7 + c, 1'b0); r++; c--; end
            push_cell(0, 1'b1);
        end
`endif
        sb[sb.size() - 1].last = 1'b1;
    endtask

    task automatic run_scan(input bit toggle, input int abort_at, input int extra_start_at);
        int  e;
        bit  got_done;
        bit  aborted;
        int  dur;
        push_scan();
        beat_cnt    = 0;
        chk_timing  = !toggle;
        got_done    = 0;
        aborted     = 0;
        dur         = 0;
        @(posedge clock); #1;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        e         = cyc;
        first_cyc = e + 1;
        check("busy_n1", int'(busy), 1);
        check("valid_n1", int'(bus.out_valid), 0);
        check("rd_addr_n1", int'(rd_addr), 0);
        for (int i = 0; i < 4 * NB + 20; i++) begin
            if (done) begin
                got_done = 1;
                dur      = i;
                break;
            end
            start = (i == extra_start_at);
            if (toggle && i > 0) bus.out_ready = ~bus.out_ready;
            if (i == abort_at + 1) reset = 1'b1;
            @(posedge clock); #1;
            if (reset) begin
                reset = 1'b0;
                check("abort_valid", int'(bus.out_valid), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_rd_addr", int'(rd_addr), 0);
                check("abort_last_done", {bus.out_last, done}, 0);
                sb.delete();
                aborted = 1;
                break;
            end
        end
        start      = 1'b0;
        chk_timing = 0;
        if (!aborted) begin
            if (!got_done) check("done_timeout", 0, 1);
            check("beats_total", beat_cnt, NB);
            check("sb_empty", sb.size(), 0);
            check("valid_after_done", int'(bus.out_valid), 0);
            if (toggle) check("stall_duration_ok", int'(dur >= 2 * NB - 2 && dur <= 2 * NB + 4), 1);
            else        check("done_cycle", dur, NB + 1);
        end
    endtask

    task automatic clear_board();
        for (int a = 0; a < 64; a++) mem[a] = EMPTY;
    endtask

    initial begin
        clear_board();
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_piece", int'(bus.out_piece), 0);
        check("rst_last", int'(bus.out_last), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;

        // empty board, full-rate consumer
        run_scan(1'b0, -10, -1);

        // red on the first four cells of row 0
        for (int a = 0; a < 4; a++) mem[a] = RED;
        run_scan(1'b0, -10, -1);
        for (int k = 0; k < 4; k++) check("red_row0", int'(got[k]), int'(RED));
        check("red_b4", int'(got[4]), int'(EMPTY));
        check("red_sep7", int'(got[7]), int'(EMPTY));
        check("red_col0", int'(got[48]), int'(RED));
        check("red_col1", int'(got[55]), int'(RED));

        // yellow in the bottom-right corner
        clear_board();
        mem[6] = YELLOW;
        run_scan(1'b0, -10, -1);
        check("yel_b6", int'(got[6]), int'(YELLOW));
        check("yel_b5", int'(got[5]), int'(EMPTY));
        check("yel_col6", int'(got[90]), int'(YELLOW));
`ifdef DIAGONALS_EN
        check("yel_ul0", int'(got[133]), int'(EMPTY));
`endif

        // mixed board with a consumer stalling every other cycle
        mem[0] = RED; mem[1] = RED; mem[8] = RED; mem[16] = YELLOW;
        mem[24] = YELLOW; mem[41] = RED; mem[20] = YELLOW;
        run_scan(1'b1, -10, -1);

        // abort at beat 50, then restart with a spurious start mid-scan
        run_scan(1'b0, 50, -1);
        run_scan(1'b0, -10, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
